// File: rtl/cpu_pkg.sv
// Shared opcode/state encodings and ALU select constants for the control sequencer.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_JMP   = 4'hB,
    OP_BEQ   = 4'hC,
    OP_BNE   = 4'hD
  } opcode_t;

  typedef enum logic [3:0] {
    ST_INIT   = 4'h0,
    ST_FETCH  = 4'h1,
    ST_DECODE = 4'h2,
    ST_LOAD_A = 4'h3,
    ST_LOAD_B = 4'h4,
    ST_STORE  = 4'h5,
    ST_ALU    = 4'h6,
    ST_BRANCH = 4'h7,
    ST_JMP    = 4'h8,
    ST_NOOP   = 4'h9,
    ST_HALT   = 4'hA,
    ST_ERR    = 4'hB
  } state_t;

  // ALU select codes share the numeric value of the matching opcode.
  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h3;
  localparam logic [3:0] ALU_SUB  = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_XOR  = 4'h8;
  localparam logic [3:0] ALU_SHL  = 4'h9;
  localparam logic [3:0] ALU_SHR  = 4'hA;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Opcode decoder: maps an instruction opcode to the post-DECODE state and ALU select.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] next_state,
  output logic [3:0] alu_sel
);

  // Purely combinational opcode lookup; unknown opcodes route to ERR.
  always_comb begin
    next_state = ST_ERR;
    alu_sel    = ALU_NONE;
    case (opcode)
      OP_NOOP:  next_state = ST_NOOP;
      OP_STORE: next_state = ST_STORE;
      OP_LOAD:  next_state = ST_LOAD_A;
      OP_ADD:   begin next_state = ST_ALU;    alu_sel = ALU_ADD; end
      OP_SUB:   begin next_state = ST_ALU;    alu_sel = ALU_SUB; end
      OP_AND:   begin next_state = ST_ALU;    alu_sel = ALU_AND; end
      OP_OR:    begin next_state = ST_ALU;    alu_sel = ALU_OR;  end
      OP_XOR:   begin next_state = ST_ALU;    alu_sel = ALU_XOR; end
      OP_SHL:   begin next_state = ST_ALU;    alu_sel = ALU_SHL; end
      OP_SHR:   begin next_state = ST_ALU;    alu_sel = ALU_SHR; end
      OP_HALT:  next_state = ST_HALT;
      OP_JMP:   next_state = ST_JMP;
      OP_BEQ:   begin next_state = ST_BRANCH; alu_sel = ALU_SUB; end
      OP_BNE:   begin next_state = ST_BRANCH; alu_sel = ALU_SUB; end
      default:  begin next_state = ST_ERR;    alu_sel = ALU_NONE; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: multi-cycle CPU control FSM with retired-instruction counter.
// Outputs are decoded combinationally from the current state and IR.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IR_W    = 16,
  parameter int REG_AW  = 4,
  parameter int DATA_AW = 8,
  parameter int PC_W    = 8,
  parameter int ALU_SW  = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [IR_W-1:0]    IR,
  input  logic               IM_VALID,
  input  logic               D_RDY,
  input  logic               ALU_Z,
  input  logic               RUN,
  output logic               PC_CLR,
  output logic               PC_IC,
  output logic               PC_LD,
  output logic               PC_REL,
  output logic [PC_W-1:0]    PC_TGT,
  output logic               IR_LD,
  output logic [DATA_AW-1:0] D_ADDR,
  output logic               D_RD,
  output logic               D_WR,
  output logic               RF_S,
  output logic               RF_W_EN,
  output logic [REG_AW-1:0]  RF_A_ADDR,
  output logic [REG_AW-1:0]  RF_B_ADDR,
  output logic [REG_AW-1:0]  RF_W_ADDR,
  output logic [ALU_SW-1:0]  ALU_S,
  output logic               HALTED,
  output logic               ILLEGAL,
  output logic [15:0]        RETIRED,
  output logic [3:0]         STATE
);

  logic [3:0]  state_r;
  logic [3:0]  next_state_s;
  logic [3:0]  dec_next_s;
  logic [3:0]  dec_alu_s;
  logic        retire_s;
  logic        br_taken_s;
  logic [15:0] retired_r;

  opcode_decoder u_opcode_decoder (
    .opcode     (IR[15:12]),
    .next_state (dec_next_s),
    .alu_sel    (dec_alu_s)
  );

  // BEQ takes the branch on a zero compare, BNE on a non-zero compare.
  assign br_taken_s = (IR[15:12] == OP_BEQ) ? ALU_Z : ~ALU_Z;

  assign STATE   = state_r;
  assign RETIRED = retired_r;

  // State register; reset forces INIT immediately.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      retired_r <= 16'h0000;
    end else if (retire_s) begin
      retired_r <= retired_r + 16'h0001;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-state, retire strobe and all control outputs; everything defaults to 0.
  always_comb begin
    next_state_s = ST_INIT;
    retire_s     = 1'b0;
    PC_CLR       = 1'b0;
    PC_IC        = 1'b0;
    PC_LD        = 1'b0;
    PC_REL       = 1'b0;
    PC_TGT       = '0;
    IR_LD        = 1'b0;
    D_ADDR       = '0;
    D_RD         = 1'b0;
    D_WR         = 1'b0;
    RF_S         = 1'b0;
    RF_W_EN      = 1'b0;
    RF_A_ADDR    = '0;
    RF_B_ADDR    = '0;
    RF_W_ADDR    = '0;
    ALU_S        = '0;
    HALTED       = 1'b0;
    ILLEGAL      = 1'b0;
    case (state_r)
      ST_INIT: begin
        PC_CLR       = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_FETCH: begin
        IR_LD        = 1'b1;
        next_state_s = IM_VALID ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        PC_IC        = 1'b1;
        next_state_s = dec_next_s;
        // HALT counts as retired on entry, since it may never be left.
        retire_s     = (dec_next_s == ST_HALT);
      end
      ST_LOAD_A: begin
        D_RD         = 1'b1;
        D_ADDR       = DATA_AW'(IR[11:4]);
        next_state_s = D_RDY ? ST_LOAD_B : ST_LOAD_A;
      end
      ST_LOAD_B: begin
        RF_S         = 1'b1;
        RF_W_EN      = 1'b1;
        RF_W_ADDR    = REG_AW'(IR[3:0]);
        next_state_s = ST_FETCH;
        retire_s     = 1'b1;
      end
      ST_STORE: begin
        D_WR         = 1'b1;
        D_ADDR       = DATA_AW'(IR[7:0]);
        RF_A_ADDR    = REG_AW'(IR[11:8]);
        next_state_s = D_RDY ? ST_FETCH : ST_STORE;
        retire_s     = D_RDY;
      end
      ST_ALU: begin
        RF_A_ADDR    = REG_AW'(IR[11:8]);
        RF_B_ADDR    = REG_AW'(IR[7:4]);
        RF_W_ADDR    = REG_AW'(IR[3:0]);
        RF_W_EN      = 1'b1;
        ALU_S        = ALU_SW'(dec_alu_s);
        next_state_s = ST_FETCH;
        retire_s     = 1'b1;
      end
      ST_BRANCH: begin
        RF_A_ADDR    = REG_AW'(IR[11:8]);
        RF_B_ADDR    = REG_AW'(IR[7:4]);
        ALU_S        = ALU_SW'(ALU_SUB);
        if (br_taken_s) begin
          PC_LD  = 1'b1;
          PC_REL = 1'b1;
          PC_TGT = {{(PC_W-4){IR[3]}}, IR[3:0]};
        end else begin
          PC_LD  = 1'b0;
          PC_REL = 1'b0;
          PC_TGT = '0;
        end
        next_state_s = ST_FETCH;
        retire_s     = 1'b1;
      end
      ST_JMP: begin
        PC_LD        = 1'b1;
        PC_TGT       = IR[PC_W-1:0];
        next_state_s = ST_FETCH;
        retire_s     = 1'b1;
      end
      ST_NOOP: begin
        next_state_s = ST_FETCH;
        retire_s     = 1'b1;
      end
      ST_HALT: begin
        HALTED       = 1'b1;
        next_state_s = RUN ? ST_FETCH : ST_HALT;
      end
      ST_ERR: begin
        HALTED       = 1'b1;
        ILLEGAL      = 1'b1;
        next_state_s = ST_ERR;
      end
      default: begin
        // Unencoded state values recover through INIT.
        next_state_s = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [15:0] IR;
  logic        IM_VALID, D_RDY, ALU_Z, RUN;
  logic        PC_CLR, PC_IC, PC_LD, PC_REL;
  logic [7:0]  PC_TGT;
  logic        IR_LD;
  logic [7:0]  D_ADDR;
  logic        D_RD, D_WR, RF_S, RF_W_EN;
  logic [3:0]  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S;
  logic        HALTED, ILLEGAL;
  logic [15:0] RETIRED;
  logic [3:0]  STATE;

  int n_pass = 0;
  int n_total = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .IM_VALID(IM_VALID), .D_RDY(D_RDY),
    .ALU_Z(ALU_Z), .RUN(RUN), .PC_CLR(PC_CLR), .PC_IC(PC_IC), .PC_LD(PC_LD),
    .PC_REL(PC_REL), .PC_TGT(PC_TGT), .IR_LD(IR_LD), .D_ADDR(D_ADDR), .D_RD(D_RD),
    .D_WR(D_WR), .RF_S(RF_S), .RF_W_EN(RF_W_EN), .RF_A_ADDR(RF_A_ADDR),
    .RF_B_ADDR(RF_B_ADDR), .RF_W_ADDR(RF_W_ADDR), .ALU_S(ALU_S), .HALTED(HALTED),
    .ILLEGAL(ILLEGAL), .RETIRED(RETIRED), .STATE(STATE)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic tick();
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b0; IR = 16'h3123; IM_VALID = 1'b1; D_RDY = 1'b0; ALU_Z = 1'b0; RUN = 1'b0;
    #1;
    chk("rst_state", 16'(STATE), 16'h0);
    chk("rst_pc_clr", 16'(PC_CLR), 16'h1);
    chk("rst_ir_ld", 16'(IR_LD), 16'h0);
    chk("rst_retired", RETIRED, 16'h0000);

    // ADD R1,R2 -> R3
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    chk("add_fetch", 16'(STATE), 16'h1);
    chk("add_ir_ld", 16'(IR_LD), 16'h1);
    tick();
    chk("add_decode", 16'(STATE), 16'h2);
    chk("add_pc_ic", 16'(PC_IC), 16'h1);
    tick();
    chk("add_state", 16'(STATE), 16'h6);
    chk("add_rf_a", 16'(RF_A_ADDR), 16'h1);
    chk("add_rf_b", 16'(RF_B_ADDR), 16'h2);
    chk("add_rf_w", 16'(RF_W_ADDR), 16'h3);
    chk("add_alu_s", 16'(ALU_S), 16'h3);
    chk("add_rf_w_en", 16'(RF_W_EN), 16'h1);
    chk("add_pc_ic_off", 16'(PC_IC), 16'h0);
    tick();
    chk("add_back_fetch", 16'(STATE), 16'h1);
    chk("add_retired", RETIRED, 16'h0001);

    // FETCH holds while IM_VALID is low
    IM_VALID = 1'b0; IR = 16'h2A55;
    tick();
    chk("fetch_hold1", 16'(STATE), 16'h1);
    tick();
    chk("fetch_hold2", 16'(STATE), 16'h1);

    // LOAD with D_RDY low for 3 cycles
    IM_VALID = 1'b1; D_RDY = 1'b0;
    tick();
    chk("ld_decode", 16'(STATE), 16'h2);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_state", 16'(STATE), 16'h3);
      chk("ld_d_rd", 16'(D_RD), 16'h1);
      chk("ld_d_addr", 16'(D_ADDR), 16'h00A5);
      tick();
    end
    D_RDY = 1'b1;
    chk("ld_wait4_state", 16'(STATE), 16'h3);
    tick();
    D_RDY = 1'b0;
    chk("ldb_state", 16'(STATE), 16'h4);
    chk("ldb_rf_w", 16'(RF_W_ADDR), 16'h5);
    chk("ldb_rf_s", 16'(RF_S), 16'h1);
    chk("ldb_rf_w_en", 16'(RF_W_EN), 16'h1);
    chk("ldb_d_rd_off", 16'(D_RD), 16'h0);
    tick();
    chk("ld_retired", RETIRED, 16'h0002);

    // BEQ R1,R2,-2
    IR = 16'hC12E; ALU_Z = 1'b1;
    tick();
    tick();
    chk("beq_state", 16'(STATE), 16'h7);
    chk("beq_pc_ld", 16'(PC_LD), 16'h1);
    chk("beq_pc_rel", 16'(PC_REL), 16'h1);
    chk("beq_pc_tgt", 16'(PC_TGT), 16'h00FE);
    chk("beq_alu_s", 16'(ALU_S), 16'h4);
    chk("beq_rf_w_en", 16'(RF_W_EN), 16'h0);
    ALU_Z = 1'b0;
    #1;
    chk("beq_nt_pc_ld", 16'(PC_LD), 16'h0);
    tick();
    chk("beq_retired", RETIRED, 16'h0003);

    // BNE taken on non-zero
    IR = 16'hD123; ALU_Z = 1'b0;
    tick();
    tick();
    chk("bne_pc_ld", 16'(PC_LD), 16'h1);
    chk("bne_pc_tgt", 16'(PC_TGT), 16'h0003);
    tick();

    // JMP absolute
    IR = 16'hB03C;
    tick();
    tick();
    chk("jmp_state", 16'(STATE), 16'h8);
    chk("jmp_pc_ld", 16'(PC_LD), 16'h1);
    chk("jmp_pc_rel", 16'(PC_REL), 16'h0);
    chk("jmp_pc_tgt", 16'(PC_TGT), 16'h003C);
    tick();
    chk("jmp_retired", RETIRED, 16'h0005);

    // STORE R7 -> [34] with one wait cycle
    IR = 16'h1734; D_RDY = 1'b0;
    tick();
    tick();
    chk("st_state", 16'(STATE), 16'h5);
    chk("st_d_wr", 16'(D_WR), 16'h1);
    chk("st_d_addr", 16'(D_ADDR), 16'h0034);
    chk("st_rf_a", 16'(RF_A_ADDR), 16'h7);
    tick();
    chk("st_hold", 16'(STATE), 16'h5);
    chk("st_hold_retired", RETIRED, 16'h0005);
    D_RDY = 1'b1;
    tick();
    D_RDY = 1'b0;
    chk("st_exit", 16'(STATE), 16'h1);
    chk("st_retired", RETIRED, 16'h0006);

    // NOOP
    IR = 16'h0000;
    tick();
    tick();
    chk("noop_state", 16'(STATE), 16'h9);
    chk("noop_pc_ic", 16'(PC_IC), 16'h0);
    tick();
    chk("noop_retired", RETIRED, 16'h0007);

    // HALT, wait 10 cycles, then RUN
    IR = 16'h5000; RUN = 1'b0;
    tick();
    tick();
    chk("halt_retired", RETIRED, 16'h0008);
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 16'(STATE), 16'hA);
      chk("halt_halted", 16'(HALTED), 16'h1);
      tick();
    end
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    chk("halt_run_fetch", 16'(STATE), 16'h1);
    chk("halt_run_halted", 16'(HALTED), 16'h0);

    // Illegal opcode
    IR = 16'hF000;
    tick();
    tick();
    chk("err_state", 16'(STATE), 16'hB);
    chk("err_illegal", 16'(ILLEGAL), 16'h1);
    chk("err_halted", 16'(HALTED), 16'h1);
    RUN = 1'b1;
    tick();
    tick();
    chk("err_run_ignored", 16'(STATE), 16'hB);
    chk("err_retired", RETIRED, 16'h0008);
    RUN = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    chk("err_async_state", 16'(STATE), 16'h0);
    chk("err_async_pc_clr", 16'(PC_CLR), 16'h1);
    chk("err_async_illegal", 16'(ILLEGAL), 16'h0);
    chk("err_async_retired", RETIRED, 16'h0000);
    @(negedge Clock);
    Reset = 1'b1;

    // Reset in the middle of a STORE wait
    IR = 16'h1734; D_RDY = 1'b0;
    tick();
    chk("st2_fetch", 16'(STATE), 16'h1);
    tick();
    tick();
    chk("st2_d_wr", 16'(D_WR), 16'h1);
    #2;
    Reset = 1'b0;
    #1;
    chk("st2_async_d_wr", 16'(D_WR), 16'h0);
    chk("st2_async_state", 16'(STATE), 16'h0);
    chk("st2_async_pc_clr", 16'(PC_CLR), 16'h1);
    chk("st2_async_retired", RETIRED, 16'h0000);
    tick();
    chk("st2_reset_held", 16'(STATE), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: IR_W 16, instruction width; REG_AW 4, register-file address width; DATA_AW 8, data-memory address width; PC_W 8, program-counter width (≤12); ALU_SW 4, ALU select width.
REQ-002 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 IR  in  IR_W  instruction register contents.
REQ-005 IM_VALID  in  1  instruction memory word valid; D_RDY  in  1  data-memory access complete; ALU_Z  in  1  ALU zero flag; RUN  in  1  restart request from HALT.
REQ-006 PC_CLR, PC_IC, PC_LD, PC_REL  out  1 each  PC clear, increment, load, relative-load select; PC_TGT  out  PC_W  load value or signed offset.
REQ-007 IR_LD  out  1; D_ADDR  out  DATA_AW; D_RD, D_WR  out  1 each.
REQ-008 RF_S, RF_W_EN  out  1 each; RF_A_ADDR, RF_B_ADDR, RF_W_ADDR  out  REG_AW each; ALU_S  out  ALU_SW.
REQ-009 HALTED, ILLEGAL  out  1 each; RETIRED  out  16  retired-instruction count; STATE  out  4  current state.

Function
REQ-010 Opcode IR[15:12] SHALL decode: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 AND, 7 OR, 8 XOR, 9 SHL, A SHR, B JMP, C BEQ, D BNE; E,F illegal.
REQ-011 States SHALL be INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ALU, BRANCH, JMP, NOOP, HALT, ERR.
REQ-012 Outputs SHALL be combinational from STATE and IR; every output not named for a state SHALL be 0.
REQ-013 INIT: PC_CLR=1; next FETCH.
REQ-014 FETCH: IR_LD=1; hold FETCH while IM_VALID=0; next DECODE.
REQ-015 DECODE: PC_IC=1 for exactly one cycle; next by opcode; illegal -> ERR.
REQ-016 LOAD_A: D_RD=1, D_ADDR=IR[11:4]; hold while D_RDY=0; next LOAD_B.
REQ-017 LOAD_B: RF_S=1, RF_W_EN=1, RF_W_ADDR=IR[3:0]; next FETCH.
REQ-018 STORE: D_WR=1, D_ADDR=IR[7:0], RF_A_ADDR=IR[11:8]; hold while D_RDY=0; next FETCH.
REQ-019 ALU (opcodes 3,4,6-A): RF_A_ADDR=IR[11:8], RF_B_ADDR=IR[7:4], RF_W_ADDR=IR[3:0], RF_W_EN=1, ALU_S=opcode; one cycle; next FETCH.
REQ-020 BRANCH (C,D): RF_A/B as REQ-019, ALU_S=SUB, RF_W_EN=0; taken when ALU_Z=1 (BEQ) or 0 (BNE); taken -> PC_LD=1, PC_REL=1, PC_TGT=sign-extended IR[3:0]; next FETCH.
REQ-021 JMP: PC_LD=1, PC_REL=0, PC_TGT=IR[PC_W-1:0]; next FETCH.
REQ-022 HALT: HALTED=1; stay until RUN=1, then FETCH.
REQ-023 ERR: ILLEGAL=1, HALTED=1; exit only by reset.
REQ-024 RETIRED SHALL increment by 1 on each exit from LOAD_B, STORE, ALU, BRANCH, JMP, NOOP, and on HALT entry; wraps FFFF->0000.
REQ-025 Unencoded state values SHALL go to INIT next cycle.

Reset
REQ-026 Reset=0 SHALL force STATE=INIT and RETIRED=0 immediately, including mid-wait in FETCH/LOAD_A/STORE; all outputs then match INIT (PC_CLR=1, others 0).
REQ-027 Release SHALL be synchronised externally; first post-release edge moves INIT->FETCH.

Structure
REQ-028 Opcode and state enums and the ALU select constants SHALL live in a shared package cpu_pkg.
REQ-029 Decode (opcode -> next state, ALU_S) SHALL be sub-module opcode_decoder; the FSM and counter stay in control_sequencer.

Verification
REQ-030 Reset release, IM_VALID=1, IR=3123 (ADD R1,R2->R3) -> INIT,FETCH,DECODE,ALU; in ALU, RF_A=1, RF_B=2, RF_W=3, ALU_S=3, RF_W_EN=1; RETIRED=1.
REQ-031 IR=2A55, D_RDY low 3 cycles -> LOAD_A held 4 cycles, D_ADDR=A5, D_RD=1; then LOAD_B with RF_W_ADDR=5, RF_S=1.
REQ-032 IR=C12E with ALU_Z=1 -> PC_LD=1, PC_REL=1, PC_TGT=FE; with ALU_Z=0 -> PC_LD=0.
REQ-033 IR=5000 -> HALTED=1 for 10 cycles with RUN=0; RUN=1 -> FETCH next cycle.
REQ-034 IR=F000 -> ERR, ILLEGAL=1; RUN ignored; Reset=0 -> INIT asynchronously.
REQ-035 Reset=0 asserted mid-STORE with D_RDY=0 -> D_WR drops without a clock edge; RETIRED=0.
